// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle between the fetch/load-store requesters, the arbiter and the single-ported memory.
// The master modport is the arbiter's view; slave is the view of the surrounding pipeline and memory.
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;

    logic              mem_req;
    logic              mem_we;
    logic [1:0]        mem_size;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_valid;

    logic              port_en;
    logic              port_rw;
    logic [1:0]        port_size;
    logic [ADDR_W-1:0] port_addr;
    logic [DATA_W-1:0] port_wdata;
    logic [DATA_W-1:0] port_rdata;
    logic              port_ready;

    modport master (
        input  if_req, if_addr, mem_req, mem_we, mem_size, mem_addr, mem_wdata,
        input  port_rdata, port_ready,
        output if_rdata, if_valid, mem_rdata, mem_valid,
        output port_en, port_rw, port_size, port_addr, port_wdata
    );

    modport slave (
        output if_req, if_addr, mem_req, mem_we, mem_size, mem_addr, mem_wdata,
        output port_rdata, port_ready,
        input  if_rdata, if_valid, mem_rdata, mem_valid,
        input  port_en, port_rw, port_size, port_addr, port_wdata
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and load/store,
// stalls the front of the pipeline while an access is in flight, and aborts hung accesses.
module unified_mem_arbiter #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    unified_mem_arbiter_if.master bus,
    output logic                 PC_LE,
    output logic                 nPC_LE,
    output logic                 IF_ID_LE,
    output logic                 err_timeout
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, SERVE_IF, SERVE_MEM} state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic             serving;
    logic             grant_mem;
    logic             grant_if;
    logic             done_ok;
    logic             abort;
    logic             stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.mem_req)     state_next = SERVE_MEM;
                else if (bus.if_req) state_next = SERVE_IF;
            end
            SERVE_IF, SERVE_MEM: begin
                if (done_ok || abort) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Load/store wins a tie because it belongs to the older instruction in the pipe.
    always_comb begin
        serving   = (state == SERVE_IF) || (state == SERVE_MEM);
        grant_mem = (state == IDLE) && bus.mem_req;
        grant_if  = (state == IDLE) && !bus.mem_req && bus.if_req;
        done_ok   = serving && bus.port_ready;
        abort     = serving && !bus.port_ready && (TIMEOUT > 0) && (wait_cnt == CNT_LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.port_en    <= 1'b0;
            bus.port_rw    <= 1'b0;
            bus.port_size  <= 2'b00;
            bus.port_addr  <= {ADDR_W{1'b0}};
            bus.port_wdata <= {DATA_W{1'b0}};
            bus.if_rdata   <= {DATA_W{1'b0}};
            bus.mem_rdata  <= {DATA_W{1'b0}};
            bus.if_valid   <= 1'b0;
            bus.mem_valid  <= 1'b0;
            err_timeout    <= 1'b0;
            wait_cnt       <= '0;
        end else begin
            bus.if_valid  <= 1'b0;
            bus.mem_valid <= 1'b0;
            if (grant_mem) begin
                bus.port_en    <= 1'b1;
                bus.port_rw    <= bus.mem_we;
                bus.port_size  <= (bus.mem_size == 2'b11) ? 2'b10 : bus.mem_size;
                bus.port_addr  <= bus.mem_addr;
                bus.port_wdata <= bus.mem_wdata;
                wait_cnt       <= '0;
            end else if (grant_if) begin
                bus.port_en   <= 1'b1;
                bus.port_rw   <= 1'b0;
                bus.port_size <= 2'b10;
                bus.port_addr <= bus.if_addr;
                wait_cnt      <= '0;
            end else if (done_ok || abort) begin
                // An aborted access still completes with zero data so no requester waits forever.
                bus.port_en <= 1'b0;
                wait_cnt    <= '0;
                if (state == SERVE_IF) begin
                    bus.if_valid <= 1'b1;
                    bus.if_rdata <= abort ? {DATA_W{1'b0}} : bus.port_rdata;
                end else begin
                    bus.mem_valid <= 1'b1;
                    if (abort)             bus.mem_rdata <= {DATA_W{1'b0}};
                    else if (!bus.port_rw) bus.mem_rdata <= bus.port_rdata;
                end
                if (abort) err_timeout <= 1'b1;
            end else if (serving) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        stall    = (bus.if_req & ~bus.if_valid) | (bus.mem_req & ~bus.mem_valid);
        PC_LE    = ~stall;
        nPC_LE   = ~stall;
        IF_ID_LE = ~stall;
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed plus randomized bench for unified_mem_arbiter; the bench plays both requesters and the memory.
module tb_unified_mem_arbiter;

    localparam int ADDR_W  = 9;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 4;

    logic clk = 1'b0;
    logic reset;
    logic PC_LE;
    logic nPC_LE;
    logic IF_ID_LE;
    logic err_timeout;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    logic [DATA_W-1:0] model_if_rdata;
    logic [DATA_W-1:0] model_mem_rdata;
    logic              model_err;

    unified_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    unified_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .PC_LE      (PC_LE),
        .nPC_LE     (nPC_LE),
        .IF_ID_LE   (IF_ID_LE),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] obs_le();
        return {PC_LE, nPC_LE, IF_ID_LE, err_timeout};
    endfunction

    // Expected load enables follow the pipeline's view: stalled while a held request has no valid yet.
    function automatic logic [3:0] exp_le(input bit if_v, input bit mem_v);
        logic stall;
        stall = (bus.if_req & ~if_v) | (bus.mem_req & ~mem_v);
        return {~stall, ~stall, ~stall, model_err};
    endfunction

    task automatic apply_stimulus(input bit ireq, input logic [ADDR_W-1:0] ia,
                                  input bit mreq, input bit we, input logic [1:0] sz,
                                  input logic [ADDR_W-1:0] ma, input logic [DATA_W-1:0] wd);
        bus.if_req    = ireq;
        bus.if_addr   = ia;
        bus.mem_req   = mreq;
        bus.mem_we    = we;
        bus.mem_size  = sz;
        bus.mem_addr  = ma;
        bus.mem_wdata = wd;
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        check_output({tag, "_port"}, bus.port_en, 1'b0);
        check_output({tag, "_valid"}, {bus.if_valid, bus.mem_valid}, 2'b00);
        check_output({tag, "_le"}, obs_le(), exp_le(1'b0, 1'b0));
    endtask

    // Memory answers after w wait states; w >= TIMEOUT means it never answers in time.
    task automatic serve(input bit is_mem, input bit we, input logic [1:0] sz,
                         input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd,
                         input logic [DATA_W-1:0] rd, input int w);
        logic [12:0] exp_port;
        bit          timed_out;
        int          n;
        timed_out = (w >= TIMEOUT);
        n = timed_out ? TIMEOUT : w + 1;
        exp_port = {1'b1, is_mem ? we : 1'b0,
                    is_mem ? ((sz == 2'b11) ? 2'b10 : sz) : 2'b10, addr};
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check_output("port_hold", {bus.port_en, bus.port_rw, bus.port_size, bus.port_addr}, exp_port);
            if (is_mem) check_output("port_wdata", bus.port_wdata, wd);
            check_output("valid_low", {bus.if_valid, bus.mem_valid}, 2'b00);
            check_output("le_busy", obs_le(), exp_le(1'b0, 1'b0));
            bus.port_ready = (k == w);
            bus.port_rdata = rd;
        end
        @(negedge clk);
        bus.port_ready = 1'b0;
        bus.port_rdata = $urandom;
        if (timed_out) model_err = 1'b1;
        check_output("valid_pulse", {bus.if_valid, bus.mem_valid}, is_mem ? 2'b01 : 2'b10);
        check_output("port_drop", bus.port_en, 1'b0);
        check_output("le_done", obs_le(), exp_le(!is_mem, is_mem));
        if (is_mem) begin
            if (timed_out) model_mem_rdata = '0;
            else if (!we)  model_mem_rdata = rd;
            check_output("mem_rdata", bus.mem_rdata, model_mem_rdata);
        end else begin
            model_if_rdata = timed_out ? '0 : rd;
            check_output("if_rdata", bus.if_rdata, model_if_rdata);
        end
    endtask

    initial begin
        logic [ADDR_W-1:0] ia;
        logic [ADDR_W-1:0] ma;
        logic [DATA_W-1:0] wd;
        logic [1:0]        sz;
        bit                we;
        int                kind;

        reset = 1'b1;
        model_err = 1'b0;
        model_if_rdata = '0;
        model_mem_rdata = '0;
        apply_stimulus(1'b0, '0, 1'b0, 1'b0, 2'b00, '0, '0);
        bus.port_ready = 1'b0;
        bus.port_rdata = '0;
        #1;
        check_output("reset_le", obs_le(), 4'b1110);
        check_output("reset_port", {bus.port_en, bus.port_rw, bus.port_size, bus.port_addr, bus.port_wdata}, 45'd0);
        check_output("reset_rdata", {bus.if_rdata, bus.mem_rdata}, 64'd0);
        check_output("reset_valid", {bus.if_valid, bus.mem_valid}, 2'b00);
        #2 reset = 1'b0;
        idle_check("idle");

        // Single fetch answered after one cycle.
        apply_stimulus(1'b1, 9'h004, 1'b0, 1'b0, 2'b00, '0, '0);
        serve(1'b0, 1'b0, 2'b10, 9'h004, '0, 32'h2002000A, 0);
        bus.if_req = 1'b0;
        idle_check("fetch_idle");

        // Collision: the load goes first, then the fetch, with no gap in the stall.
        wd = $urandom;
        apply_stimulus(1'b1, 9'h0C8, 1'b1, 1'b0, 2'b10, 9'h010, wd);
        serve(1'b1, 1'b0, 2'b10, 9'h010, wd, 32'hCAFE0010, 1);
        bus.mem_req = 1'b0;
        serve(1'b0, 1'b0, 2'b10, 9'h0C8, '0, 32'h8C020004, 0);
        bus.if_req = 1'b0;
        idle_check("collide_idle");

        // Byte store with three wait states; ready lands on the last cycle before the watchdog.
        apply_stimulus(1'b0, '0, 1'b1, 1'b1, 2'b00, 9'h021, 32'h000000AB);
        serve(1'b1, 1'b1, 2'b00, 9'h021, 32'h000000AB, 32'hFFFFFFFF, 3);
        bus.mem_req = 1'b0;
        idle_check("store_idle");

        // Fetch the memory never answers.
        apply_stimulus(1'b1, 9'h030, 1'b0, 1'b0, 2'b00, '0, '0);
        serve(1'b0, 1'b0, 2'b10, 9'h030, '0, 32'h12345678, 6);
        bus.if_req = 1'b0;
        idle_check("timeout_idle");

        for (int i = 0; i < 16; i++) begin
            kind = $urandom_range(0, 2);
            ia = ADDR_W'($urandom);
            ma = ADDR_W'($urandom);
            wd = $urandom;
            sz = 2'($urandom_range(0, 3));
            we = 1'($urandom_range(0, 1));
            apply_stimulus(kind != 1, ia, kind != 0, we, sz, ma, wd);
            if (kind != 0) begin
                serve(1'b1, we, sz, ma, wd, $urandom, $urandom_range(0, 5));
                bus.mem_req = 1'b0;
            end
            if (kind != 1) begin
                serve(1'b0, 1'b0, 2'b10, ia, '0, $urandom, $urandom_range(0, 5));
                bus.if_req = 1'b0;
            end
            idle_check("rand_idle");
        end

        // Reset two cycles into a load abandons it without a valid pulse.
        apply_stimulus(1'b0, '0, 1'b1, 1'b0, 2'b10, 9'h044, '0);
        @(negedge clk);
        check_output("rst_mid_en", bus.port_en, 1'b1);
        @(negedge clk);
        #2 reset = 1'b1;
        bus.mem_req = 1'b0;
        model_err = 1'b0;
        model_mem_rdata = '0;
        model_if_rdata = '0;
        #1;
        check_output("rst_async_port", bus.port_en, 1'b0);
        check_output("rst_async_flags", {bus.mem_valid, obs_le()}, 5'b01110);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) idle_check("post_rst");

        apply_stimulus(1'b0, '0, 1'b1, 1'b0, 2'b01, 9'h048, 32'h5A5A5A5A);
        serve(1'b1, 1'b0, 2'b01, 9'h048, 32'h5A5A5A5A, 32'h0000BEEF, 1);
        bus.mem_req = 1'b0;
        idle_check("final_idle");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
